// File: rtl/wb_reg_file.sv
// wb_reg_file: integer register file at the consumer end of the writeback path.
//
// Commits the writeback word to the register array, serves two decode-stage read
// ports with same-cycle write-through bypass, and keeps a one-bit-per-register
// scoreboard for long-latency producers so decode can stall on a dependent read.
//
// Ports
//   clk, reset                 clock and asynchronous active-high reset
//   io_wb_en/addr/wd           writeback commit (x0 writes dropped)
//   io_rsN_en/addr             read port N enable (stall qualifier) and address
//   io_rsN_data/busy           read port N data (bypassed) and busy flag
//   io_sb_set/addr             mark destination of an issuing long-latency op busy
//   io_stall                   an enabled source is waiting on a producer
//   io_busy_vec                raw scoreboard state, bit i = register i busy
module wb_reg_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_wb_en,
    input  logic [AW-1:0]    io_wb_addr,
    input  logic [XLEN-1:0]  io_wb_wd,
    input  logic             io_rs1_en,
    input  logic [AW-1:0]    io_rs1_addr,
    output logic [XLEN-1:0]  io_rs1_data,
    output logic             io_rs1_busy,
    input  logic             io_rs2_en,
    input  logic [AW-1:0]    io_rs2_addr,
    output logic [XLEN-1:0]  io_rs2_data,
    output logic             io_rs2_busy,
    input  logic             io_sb_set,
    input  logic [AW-1:0]    io_sb_addr,
    output logic             io_stall,
    output logic [NREGS-1:0] io_busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;
    logic             rs1_hit;
    logic             rs2_hit;

    // Register array; entry 0 is never written and never read out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (io_wb_en && (io_wb_addr != '0)) begin
            regs_q[io_wb_addr] <= io_wb_wd;
        end
    end

    // Scoreboard next state: a set in the same cycle as a clearing writeback wins,
    // because the set belongs to a newer producer of the same register.
    always_comb begin
        sb_d = sb_q;
        for (int i = 1; i < int'(NREGS); i++) begin
            if (io_sb_set && (io_sb_addr == AW'(i))) begin
                sb_d[i] = 1'b1;
            end else if (io_wb_en && (io_wb_addr == AW'(i))) begin
                sb_d[i] = 1'b0;
            end
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // A source being written this cycle is served by the bypass, so its
    // clearing writeback also hides the busy bit in the same cycle.
    assign rs1_hit = io_wb_en && (io_wb_addr == io_rs1_addr);
    assign rs2_hit = io_wb_en && (io_wb_addr == io_rs2_addr);

    assign io_rs1_data = (io_rs1_addr == '0) ? '0 :
                         rs1_hit             ? io_wb_wd : regs_q[io_rs1_addr];
    assign io_rs2_data = (io_rs2_addr == '0) ? '0 :
                         rs2_hit             ? io_wb_wd : regs_q[io_rs2_addr];

    assign io_rs1_busy = sb_q[io_rs1_addr] && !rs1_hit;
    assign io_rs2_busy = sb_q[io_rs2_addr] && !rs2_hit;

    assign io_stall    = (io_rs1_en && io_rs1_busy) || (io_rs2_en && io_rs2_busy);
    assign io_busy_vec = sb_q;

endmodule
